hs32_fetch: RTL and testbench
=============================

// Module: hs32_fetch
// PURPOSE
// Instruction fetch unit with prefetch queue, directly upstream of the internal memory arbiter
// (hs32_mem). Drives arbiter channel 0 (read-only), buffers fetched words with their PC in a
// small FIFO, presents them to decode via valid/ready. A redirect (branch/exception) flushes the queue.
// PARAMETERS
// DEPTH     4          prefetch FIFO entries; power of two, >=2
// RESET_PC  32'h0      first fetch address after reset
// PORTS
// clk          in   1   clock, all state on rising edge
// reset        in   1   asynchronous, active-low reset
// newpc        in   32  redirect target; word-aligned, bits[1:0] ignored
// newpc_valid  in   1   redirect strobe, one cycle; wins over all other events
// addr         out  32  fetch address to arbiter channel
// rw           out  1   always 0 (read)
// req          out  1   request to arbiter; held with addr stable until ack
// ack          in   1   one-cycle completion pulse; data valid on dtr that cycle
// dtr          in   32  read data from arbiter
// instr        out  32  instruction word at FIFO head
// instr_pc     out  32  address of instr
// instr_valid  out  1   FIFO non-empty
// instr_ready  in   1   decode consumes head when instr_valid && instr_ready
// BEHAVIOUR
// - Reset (async assert, sync release): fpc=RESET_PC, state=IDLE, FIFO empty, req=0, addr=0,
//   rw=0, instr_valid=0, instr/instr_pc=0.
// - FSM: IDLE -> REQ when count<DEPTH (and no redirect); addr<=fpc, req<=1.
//   REQ: on ack, push {fpc,dtr}, fpc<=fpc+4, req<=0, -> IDLE. Next req earliest cycle after ack.
//   REQ + newpc_valid (no ack): -> DISCARD; req/addr held (arbiter contract: never drop req early).
//   DISCARD: on ack, data dropped, req<=0, -> IDLE. Further redirects in DISCARD only update fpc.
// - Redirect: FIFO cleared same edge, fpc<=newpc&~3. From IDLE new req issues next cycle (t+1).
//   Redirect in the ack cycle: acked word discarded, not pushed; -> IDLE.
// - Slot reservation: request issued only if count<DEPTH; count cannot rise before ack, so push
//   never overflows. Full FIFO: stay IDLE, req=0.
// - Simultaneous push and pop: count unchanged; push into empty FIFO visible next cycle
//   (instr_valid one cycle after ack; no bypass).
// - Pop with redirect same cycle: FIFO cleared; pop has no further effect.
// - fpc arithmetic 32-bit modulo: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
// - count width $clog2(DEPTH)+1; pointers wrap modulo DEPTH.
// - Reset mid-request: req drops immediately (async); arbiter must treat as abort.
// STRUCTURE
// - Package hs32_pkg: fetch FSM state encodings (IDLE/REQ/DISCARD), RW_READ=1'b0, WORD_BYTES=4.
// - Sub-module hs32_fifo (parameter WIDTH=64, DEPTH): push/pop/clear, full/empty/count,
//   registered outputs; fetch wraps it with FSM + PC register.
// TESTING
// - Reset, ack 2 cycles after each req, ready=1 -> addrs 0,4,8,...; instr_pc matches; instr_valid 1 cycle after ack.
// - ready=0, ack immediate -> exactly 4 words queued, req stays 0 while count=4; one pop -> next req next cycle.
// - newpc=32'h100 while REQ pending, ack 3 cycles later -> req held, acked word dropped, next req addr=32'h100, FIFO empty until then.
// - newpc_valid in same cycle as ack and as pop -> FIFO empty next cycle, no push, next addr=newpc.
// - newpc=32'hFFFF_FFFC -> fetch addrs FFFF_FFFC then 0000_0000; newpc=32'h103 -> addr 32'h100.
// - Async reset asserted mid-REQ -> req=0, instr_valid=0 same cycle; after release first addr=RESET_PC.

Source files
------------

// File: rtl/hs32_pkg.sv
// hs32 fetch-path shared definitions: FSM encodings, bus constants and the
// prefetch queue entry layout.
package hs32_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    localparam logic        RW_READ    = 1'b0;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_ent_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/hs32_fifo.sv
// hs32 prefetch FIFO: single-clock, power-of-two depth, synchronous clear
// that wins over push and pop.
module hs32_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hs32_fetch.sv
// hs32 instruction fetch: one outstanding read on arbiter channel 0, words
// buffered with their PC in a prefetch FIFO, flushed by redirects.
module hs32_fetch
    import hs32_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] newpc,
    input  logic        newpc_valid,
    output logic [31:0] addr,
    output logic        rw,
    output logic        req,
    input  logic        ack,
    input  logic [31:0] dtr,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;
    logic          push;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    fetch_ent_t    wr_ent;
    fetch_ent_t    head;

    assign addr        = addr_q;
    assign req         = req_q;
    assign rw          = RW_READ;
    assign instr       = head.word;
    assign instr_pc    = head.pc;
    assign instr_valid = !empty;
    assign wr_ent      = '{pc: fpc_q, word: dtr};

    // A request is only launched with a free slot, so the ack can always push.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        push    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (newpc_valid) begin
                    fpc_d = word_align(newpc);
                end else if (!full) begin
                    addr_d  = fpc_q;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (newpc_valid) begin
                    fpc_d = word_align(newpc);
                    if (ack) begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end else if (ack) begin
                    push    = 1'b1;
                    fpc_d   = fpc_q + WORD_BYTES;
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (newpc_valid) begin
                    fpc_d = word_align(newpc);
                end
                if (ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            fpc_q   <= RESET_PC;
            addr_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    hs32_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .wdata_i (wr_ent),
        .pop_i   (instr_ready),
        .clear_i (newpc_valid),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (count <= CW'(DEPTH));
        end
    end

endmodule

// File: tb/tb_hs32_fetch.sv
// Scoreboard bench for hs32_fetch: a randomized arbiter model feeds words,
// the monitor predicts the fetch stream from the PC/redirect rules.
module tb_hs32_fetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] newpc;
    logic        newpc_valid;
    logic [31:0] addr;
    logic        rw;
    logic        req;
    logic        ack;
    logic [31:0] dtr;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int n_vec = 0;
    int n_bad = 0;
    int n_pop = 0;
    int lat_lo = 0;
    int lat_hi = 0;

    logic [63:0] exp_q[$];
    logic [31:0] addr_log[$];
    logic [31:0] mpc;
    bit          dirty;
    bit          req_prev;

    hs32_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .newpc       (newpc),
        .newpc_valid (newpc_valid),
        .addr        (addr),
        .rw          (rw),
        .req         (req),
        .ack         (ack),
        .dtr         (dtr),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
        end
    endtask

    // Arbiter model: ack 'lat' cycles after req is first seen.
    bit busy = 0;
    int wait_c = 0;
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            ack  = 1'b0;
            busy = 0;
        end else if (ack) begin
            ack  = 1'b0;
            busy = 0;
        end else if (req) begin
            if (!busy) begin
                busy   = 1;
                wait_c = int'($urandom_range(lat_hi, lat_lo));
            end else begin
                wait_c = wait_c - 1;
            end
            if (wait_c <= 0) begin
                ack = 1'b1;
                dtr = memf(addr);
            end
        end
    end

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            addr_log.delete();
            mpc      = RESET_PC;
            dirty    = 0;
            req_prev = 0;
        end else begin
            check("valid_vs_model", {31'b0, instr_valid},
                  {31'b0, exp_q.size() != 0});
            check("rw", {31'b0, rw}, 32'h0);
            if (req && !req_prev) begin
                check("fetch_addr", addr, mpc);
                addr_log.push_back(addr);
            end
            if (req) begin
                check("slot_free", {31'b0, exp_q.size() < DEPTH}, 32'h1);
                if (newpc_valid) dirty = 1;
            end
            if (instr_valid && instr_ready && !newpc_valid) begin
                check("pop_nonempty", {31'b0, exp_q.size() != 0}, 32'h1);
                if (exp_q.size() != 0) begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("pop_pc", instr_pc, e[63:32]);
                    check("pop_word", instr, e[31:0]);
                    n_pop++;
                end
            end
            if (req && ack && !dirty) begin
                exp_q.push_back({addr, memf(addr)});
                mpc = addr + 32'd4;
            end
            if (newpc_valid) begin
                exp_q.delete();
                mpc = newpc & ~32'd3;
            end
            if (req && ack) dirty = 0;
            req_prev = req && !ack;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_req_rise(input string nm);
        bit prev;
        bit hit;
        prev = req;
        hit  = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (req && !prev) begin
                hit = 1;
                break;
            end
            prev = req;
        end
        check(nm, {31'b0, hit}, 32'h1);
    endtask

    task automatic redirect(input logic [31:0] pc);
        newpc       = pc;
        newpc_valid = 1'b1;
        step(1);
        newpc_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0;
        bit hit;
        reset       = 1'b0;
        newpc       = 32'h0;
        newpc_valid = 1'b0;
        instr_ready = 1'b0;
        ack         = 1'b0;
        dtr         = 32'h0;
        step(2);
        check("rst_req", {31'b0, req}, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_rw", {31'b0, rw}, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        reset = 1'b1;

        // Sequential fetch, ack two cycles after each request.
        lat_lo = 2; lat_hi = 2;
        instr_ready = 1'b1;
        step(40);
        check("seq_first_addr", addr_log[0], RESET_PC);
        check("seq_third_addr", addr_log[2], RESET_PC + 32'd8);

        // Stalled decode: queue fills to DEPTH, then request stops.
        instr_ready = 1'b0;
        lat_lo = 0; lat_hi = 0;
        step(30);
        check("full_count", exp_q.size(), DEPTH);
        check("full_valid", {31'b0, instr_valid}, 32'h1);
        check("full_no_req", {31'b0, req}, 32'h0);
        instr_ready = 1'b1;
        step(1);
        instr_ready = 1'b0;
        check("pop_same_cycle_no_req", {31'b0, req}, 32'h0);
        step(1);
        check("req_after_pop", {31'b0, req}, 32'h1);

        // Redirect while a request is outstanding.
        instr_ready = 1'b1;
        lat_lo = 3; lat_hi = 3;
        step(10);
        wait_req_rise("t3_req_rise");
        redirect(32'h100);
        addr_log.delete();
        check("req_held", {31'b0, req}, 32'h1);
        check("flush_valid", {31'b0, instr_valid}, 32'h0);
        step(20);
        check("t3_next_addr", addr_log[0], 32'h100);

        // Redirect coinciding with ack and pop.
        instr_ready = 1'b0;
        lat_lo = 1; lat_hi = 1;
        hit = 0;
        for (int i = 0; i < 60; i++) begin
            if (ack && instr_valid) begin
                hit = 1;
                break;
            end
            step(1);
        end
        check("t4_found", {31'b0, hit}, 32'h1);
        instr_ready = 1'b1;
        redirect(32'h2000);
        addr_log.delete();
        check("t4_empty", {31'b0, instr_valid}, 32'h0);
        step(20);
        check("t4_next_addr", addr_log[0], 32'h2000);

        // PC wrap and misaligned target.
        redirect(32'hFFFF_FFFC);
        addr_log.delete();
        step(20);
        check("wrap_a0", addr_log[0], 32'hFFFF_FFFC);
        check("wrap_a1", addr_log[1], 32'h0000_0000);
        redirect(32'h103);
        addr_log.delete();
        step(20);
        check("align_addr", addr_log[0], 32'h100);

        // Asynchronous reset in the middle of a request.
        lat_lo = 5; lat_hi = 5;
        wait_req_rise("t6_req_rise");
        reset = 1'b0;
        #1;
        check("async_req", {31'b0, req}, 32'h0);
        check("async_valid", {31'b0, instr_valid}, 32'h0);
        step(2);
        reset = 1'b1;
        addr_log.delete();
        lat_lo = 1; lat_hi = 1;
        step(20);
        check("post_reset_addr", addr_log[0], RESET_PC);

        // Randomized traffic.
        lat_lo = 0; lat_hi = 4;
        pops0 = n_pop;
        for (int i = 0; i < 1500; i++) begin
            instr_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(11, 0) == 0) begin
                newpc_valid = 1'b1;
                if ($urandom_range(3, 0) == 0)
                    newpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                else
                    newpc = $urandom;
            end else begin
                newpc_valid = 1'b0;
            end
            step(1);
        end
        newpc_valid = 1'b0;
        instr_ready = 1'b1;
        step(30);
        check("random_progress", {31'b0, n_pop > pops0 + 100}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
